// File: rtl/reconfig_pkg.sv
// Shared types and default opcodes for the UART reconfiguration/dump controller.
package reconfig_pkg;

    typedef enum logic [3:0] {
        TRACING,
        CFG_ID,
        CFG_DATA,
        HDR_START,
        HDR_COUNT,
        SETTLE,
        MEM_WAIT,
        LOAD,
        SEND,
        WAIT_TX,
        NEXT
    } rcfg_state_t;

    localparam logic [7:0] DEFAULT_CMD_CONFIG = 8'h2A;
    localparam logic [7:0] DEFAULT_CMD_DUMP   = 8'h44;
    localparam logic [7:0] DEFAULT_CMD_ABORT  = 8'h58;

    // A count byte of zero asks for the whole trace buffer.
    function automatic logic [8:0] entry_count(input logic [7:0] count_byte, input int tb_size);
        return (count_byte == 8'd0) ? 9'(tb_size) : {1'b0, count_byte};
    endfunction

endpackage

// File: rtl/byte_serializer.sv
// Shifts one trace-buffer entry out to the UART a byte at a time, LSB first,
// pacing each byte on the UART busy handshake.
module byte_serializer #(
    parameter int BYTES = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               start,
    input  logic [BYTES*8-1:0] vector_flat,
    input  logic               tx_busy,
    output logic [7:0]         tx_data,
    output logic               new_tx_data,
    output logic               done,
    output logic               all_sent
);

    localparam int CW = $clog2(BYTES + 1);

    logic [BYTES*8-1:0] shift_reg;
    logic [CW-1:0]      byte_cnt;
    logic               pending;
    logic               guard;

    // The guard cycle gives the UART one cycle to raise tx_busy before it is trusted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_reg   <= '0;
            byte_cnt    <= '0;
            pending     <= 1'b0;
            guard       <= 1'b0;
            tx_data     <= 8'd0;
            new_tx_data <= 1'b0;
            done        <= 1'b0;
        end else begin
            new_tx_data <= 1'b0;
            done        <= 1'b0;
            if (load) begin
                shift_reg <= vector_flat;
                byte_cnt  <= '0;
            end else if (start) begin
                tx_data     <= shift_reg[7:0];
                new_tx_data <= 1'b1;
                pending     <= 1'b1;
                guard       <= 1'b1;
            end else if (pending) begin
                if (guard) begin
                    guard <= 1'b0;
                end else if (!tx_busy) begin
                    pending   <= 1'b0;
                    shift_reg <= shift_reg >> 8;
                    byte_cnt  <= byte_cnt + CW'(1);
                    done      <= 1'b1;
                end
            end
        end
    end

    assign all_sent = (byte_cnt == CW'(BYTES));

endmodule

// File: rtl/reconfig_dump_unit.sv
// Byte-command decoder between the UART and the instrumentation: emits config
// strobes and dumps address ranges of the trace buffer to the UART TX.
module reconfig_dump_unit
    import reconfig_pkg::*;
#(
    parameter int          N             = 8,
    parameter int          TB_SIZE       = 8,
    parameter int          DATA_WIDTH    = 32,
    parameter int          MEM_LATENCY   = 2,
    parameter int unsigned SETTLE_CYCLES = 25000000,
    parameter logic [7:0]  CMD_CONFIG    = DEFAULT_CMD_CONFIG,
    parameter logic [7:0]  CMD_DUMP      = DEFAULT_CMD_DUMP,
    parameter logic [7:0]  CMD_ABORT     = DEFAULT_CMD_ABORT
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [7:0]                 rx_data,
    input  logic                       new_rx_data,
    output logic [7:0]                 tx_data,
    output logic                       new_tx_data,
    input  logic                       tx_busy,
    output logic                       tracing,
    output logic                       cfg_valid,
    output logic [7:0]                 cfg_id,
    output logic [7:0]                 cfg_data,
    output logic [$clog2(TB_SIZE)-1:0] tb_mem_address,
    input  logic [DATA_WIDTH-1:0]      vector_out_tb [N-1:0]
);

    localparam int AW    = $clog2(TB_SIZE);
    localparam int BYTES = N * DATA_WIDTH / 8;

    rcfg_state_t             state;
    logic [AW-1:0]           cur_addr;
    logic [8:0]              entries_left;
    logic [31:0]             settle_cnt;
    logic [3:0]              lat_cnt;
    logic                    abort_flag;
    logic                    abort_rx;
    logic                    ser_done;
    logic                    ser_all_sent;
    logic [N*DATA_WIDTH-1:0] vector_flat;

    for (genvar i = 0; i < N; i++) begin : g_flatten
        assign vector_flat[i*DATA_WIDTH +: DATA_WIDTH] = vector_out_tb[i];
    end

    assign abort_rx = new_rx_data && (rx_data == CMD_ABORT);

    byte_serializer #(
        .BYTES(BYTES)
    ) u_serializer (
        .clk        (clk),
        .rst        (rst),
        .load       (state == LOAD),
        .start      (state == SEND),
        .vector_flat(vector_flat),
        .tx_busy    (tx_busy),
        .tx_data    (tx_data),
        .new_tx_data(new_tx_data),
        .done       (ser_done),
        .all_sent   (ser_all_sent)
    );

    // Every exit back to TRACING also restores the tracing output and drops a pending abort.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= TRACING;
            tracing        <= 1'b1;
            cfg_valid      <= 1'b0;
            cfg_id         <= 8'd0;
            cfg_data       <= 8'd0;
            tb_mem_address <= '0;
            cur_addr       <= '0;
            entries_left   <= 9'd0;
            settle_cnt     <= 32'd0;
            lat_cnt        <= 4'd0;
            abort_flag     <= 1'b0;
        end else begin
            cfg_valid <= 1'b0;
            if (abort_rx && !tracing) begin
                abort_flag <= 1'b1;
            end
            case (state)
                TRACING: begin
                    if (new_rx_data) begin
                        if (rx_data == CMD_CONFIG) begin
                            state <= CFG_ID;
                        end else if (rx_data == CMD_DUMP) begin
                            state <= HDR_START;
                        end
                    end
                end
                CFG_ID: begin
                    if (new_rx_data) begin
                        cfg_id <= rx_data;
                        state  <= CFG_DATA;
                    end
                end
                CFG_DATA: begin
                    if (new_rx_data) begin
                        cfg_data  <= rx_data;
                        cfg_valid <= 1'b1;
                        state     <= TRACING;
                    end
                end
                HDR_START: begin
                    if (new_rx_data) begin
                        cur_addr <= rx_data[AW-1:0];
                        state    <= HDR_COUNT;
                    end
                end
                HDR_COUNT: begin
                    if (new_rx_data) begin
                        entries_left <= entry_count(rx_data, TB_SIZE);
                        settle_cnt   <= 32'd0;
                        tracing      <= 1'b0;
                        state        <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (abort_rx || abort_flag) begin
                        settle_cnt   <= 32'd0;
                        entries_left <= 9'd0;
                        abort_flag   <= 1'b0;
                        tracing      <= 1'b1;
                        state        <= TRACING;
                    end else if (settle_cnt == SETTLE_CYCLES) begin
                        settle_cnt     <= 32'd0;
                        tb_mem_address <= cur_addr;
                        lat_cnt        <= 4'd0;
                        state          <= MEM_WAIT;
                    end else begin
                        settle_cnt <= settle_cnt + 32'd1;
                    end
                end
                MEM_WAIT: begin
                    if (lat_cnt == 4'(MEM_LATENCY - 1)) begin
                        lat_cnt <= 4'd0;
                        state   <= LOAD;
                    end else begin
                        lat_cnt <= lat_cnt + 4'd1;
                    end
                end
                LOAD:    state <= SEND;
                SEND:    state <= WAIT_TX;
                WAIT_TX: begin
                    if (ser_done) begin
                        state <= NEXT;
                    end
                end
                NEXT: begin
                    if (abort_rx || abort_flag) begin
                        entries_left <= 9'd0;
                        abort_flag   <= 1'b0;
                        tracing      <= 1'b1;
                        state        <= TRACING;
                    end else if (!ser_all_sent) begin
                        state <= SEND;
                    end else if (entries_left > 9'd1) begin
                        entries_left   <= entries_left - 9'd1;
                        cur_addr       <= cur_addr + AW'(1);
                        tb_mem_address <= cur_addr + AW'(1);
                        state          <= MEM_WAIT;
                    end else begin
                        entries_left <= 9'd0;
                        abort_flag   <= 1'b0;
                        tracing      <= 1'b1;
                        state        <= TRACING;
                    end
                end
                default: begin
                    tracing <= 1'b1;
                    state   <= TRACING;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reconfig_dump_unit.sv
// Scoreboard bench for reconfig_dump_unit: a latency-modelled trace buffer and a
// UART stub feed the DUT, while TX bytes and config strobes are checked against queues.
module tb_reconfig_dump_unit;

    localparam int N          = 2;
    localparam int DW         = 16;
    localparam int TBS        = 8;
    localparam int LAT        = 2;
    localparam int SETTLE     = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [7:0]     rx_data = 8'd0;
    logic           new_rx_data = 1'b0;
    logic [7:0]     tx_data;
    logic           new_tx_data;
    logic           tx_busy = 1'b0;
    logic           tracing;
    logic           cfg_valid;
    logic [7:0]     cfg_id;
    logic [7:0]     cfg_data;
    logic [2:0]     tb_mem_address;
    logic [DW-1:0]  vector_out_tb [N-1:0];

    logic [DW-1:0]  mem [TBS][N];
    logic [2:0]     addr_d1 = 3'd0;
    logic [2:0]     addr_d2 = 3'd0;

    logic [7:0]     tx_q [$];
    logic [15:0]    cfg_q [$];
    int             vectors = 0;
    int             miscompares = 0;
    int             busy_cycles = 2;
    int             busy_left = 0;

    reconfig_dump_unit #(
        .N            (N),
        .TB_SIZE      (TBS),
        .DATA_WIDTH   (DW),
        .MEM_LATENCY  (LAT),
        .SETTLE_CYCLES(SETTLE)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .rx_data       (rx_data),
        .new_rx_data   (new_rx_data),
        .tx_data       (tx_data),
        .new_tx_data   (new_tx_data),
        .tx_busy       (tx_busy),
        .tracing       (tracing),
        .cfg_valid     (cfg_valid),
        .cfg_id        (cfg_id),
        .cfg_data      (cfg_data),
        .tb_mem_address(tb_mem_address),
        .vector_out_tb (vector_out_tb)
    );

    always #5 clk = ~clk;

    // Trace buffer: read data follows the address after LAT clock edges.
    always @(posedge clk) begin
        addr_d1 <= tb_mem_address;
        addr_d2 <= addr_d1;
    end
    assign vector_out_tb[0] = mem[addr_d2][0];
    assign vector_out_tb[1] = mem[addr_d2][1];

    // UART stub: raises busy half a cycle after each request and holds it busy_cycles cycles.
    always @(negedge clk) begin
        if (new_tx_data) begin
            tx_busy = 1'b1;
            busy_left = busy_cycles;
        end else if (busy_left > 0) begin
            busy_left = busy_left - 1;
            if (busy_left == 0) tx_busy = 1'b0;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Output monitor: every TX byte and config strobe must match the head of its queue.
    always @(negedge clk) begin
        if (!rst && new_tx_data) begin
            if (tx_q.size() == 0) checkOutput("tx_unexpected", {24'd0, tx_data}, 32'h100);
            else checkOutput("tx_byte", {24'd0, tx_data}, {24'd0, tx_q.pop_front()});
        end
        if (!rst && cfg_valid) begin
            if (cfg_q.size() == 0) checkOutput("cfg_unexpected", {16'd0, cfg_id, cfg_data}, 32'h10000);
            else checkOutput("cfg_strobe", {16'd0, cfg_id, cfg_data}, {16'd0, cfg_q.pop_front()});
        end
    end

    task automatic applyStimulus(input logic [7:0] b);
        @(posedge clk);
        #1;
        rx_data = b;
        new_rx_data = 1'b1;
        @(posedge clk);
        #1;
        new_rx_data = 1'b0;
        @(posedge clk);
    endtask

    task automatic pushEntry(input int a);
        logic [DW-1:0] l0;
        logic [DW-1:0] l1;
        l0 = mem[a][0];
        l1 = mem[a][1];
        tx_q.push_back(l0[7:0]);
        tx_q.push_back(l0[15:8]);
        tx_q.push_back(l1[7:0]);
        tx_q.push_back(l1[15:8]);
    endtask

    task automatic dump(input logic [7:0] start, input logic [7:0] count);
        int n;
        n = (count == 8'd0) ? TBS : int'(count);
        for (int i = 0; i < n; i++) pushEntry((int'(start) + i) % TBS);
        applyStimulus(8'h44);
        applyStimulus(start);
        applyStimulus(count);
    endtask

    task automatic waitTracing(input string tag, input int max_cycles);
        int n;
        n = 0;
        while (!tracing && n < max_cycles) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        checkOutput(tag, {31'd0, tracing}, 32'd1);
        checkOutput({tag, "_missing"}, 32'(tx_q.size()), 32'd0);
    endtask

    task automatic waitTxPulses(input string tag, input int count);
        int seen;
        int n;
        seen = 0;
        n = 0;
        while (seen < count && n < 1000) begin
            @(negedge clk);
            if (new_tx_data) seen++;
            n++;
        end
        checkOutput(tag, 32'(seen), 32'(count));
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int a = 0; a < TBS; a++) begin
            mem[a][0] = 16'hA1B2 + 16'(a) * 16'h1111;
            mem[a][1] = 16'hC3D4 + 16'(a) * 16'h1010;
        end

        #1;
        repeat (3) @(negedge clk);
        checkOutput("rst_tracing", {31'd0, tracing}, 32'd1);
        checkOutput("rst_new_tx", {31'd0, new_tx_data}, 32'd0);
        checkOutput("rst_tx_data", {24'd0, tx_data}, 32'd0);
        checkOutput("rst_cfg", {15'd0, cfg_valid, cfg_id, cfg_data}, 32'd0);
        checkOutput("rst_addr", {29'd0, tb_mem_address}, 32'd0);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        checkOutput("idle_tracing", {31'd0, tracing}, 32'd1);

        applyStimulus(8'h00);
        applyStimulus(8'h58);
        checkOutput("stray_tracing", {31'd0, tracing}, 32'd1);

        cfg_q.push_back(16'h057F);
        applyStimulus(8'h2A);
        checkOutput("cfg_mid_tracing", {31'd0, tracing}, 32'd1);
        applyStimulus(8'h05);
        applyStimulus(8'h7F);
        repeat (3) @(negedge clk);
        checkOutput("cfg_hold", {16'd0, cfg_id, cfg_data}, 32'h057F);
        checkOutput("cfg_pending", 32'(cfg_q.size()), 32'd0);

        tx_q.push_back(8'hB2);
        tx_q.push_back(8'hA1);
        tx_q.push_back(8'hD4);
        tx_q.push_back(8'hC3);
        applyStimulus(8'h44);
        applyStimulus(8'h00);
        applyStimulus(8'h01);
        checkOutput("dump_not_tracing", {31'd0, tracing}, 32'd0);
        waitTracing("dump_single", 500);

        dump(8'h06, 8'h04);
        waitTracing("dump_wrap", 1000);

        dump(8'h03, 8'h00);
        waitTracing("dump_full", 2000);

        busy_cycles = 4;
        tx_q.push_back(mem[2][0][7:0]);
        tx_q.push_back(mem[2][0][15:8]);
        applyStimulus(8'h44);
        applyStimulus(8'h02);
        applyStimulus(8'h03);
        waitTxPulses("abort_sync", 2);
        applyStimulus(8'h58);
        waitTracing("abort_tx", 500);
        repeat (60) @(negedge clk);

        applyStimulus(8'h44);
        applyStimulus(8'h01);
        applyStimulus(8'h02);
        applyStimulus(8'h58);
        waitTracing("abort_settle", 100);
        repeat (60) @(negedge clk);

        busy_cycles = 10;
        dump(8'h05, 8'h02);
        waitTxPulses("slow_first", 1);
        applyStimulus(8'h2A);
        waitTracing("dump_slow", 2000);

        busy_cycles = 2;
        dump(8'h00, 8'h03);
        waitTxPulses("rst_sync", 3);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("midrst_tracing", {31'd0, tracing}, 32'd1);
        checkOutput("midrst_new_tx", {31'd0, new_tx_data}, 32'd0);
        checkOutput("midrst_tx_data", {24'd0, tx_data}, 32'd0);
        checkOutput("midrst_addr", {29'd0, tb_mem_address}, 32'd0);
        tx_q.delete();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (60) @(negedge clk);
        checkOutput("post_rst_cfg", {16'd0, cfg_id, cfg_data}, 32'd0);

        cfg_q.push_back(16'h1122);
        applyStimulus(8'h2A);
        applyStimulus(8'h11);
        applyStimulus(8'h22);
        dump(8'h07, 8'h02);
        waitTracing("dump_recover", 1000);
        checkOutput("cfg_final", {16'd0, cfg_id, cfg_data}, 32'h1122);
        checkOutput("cfg_final_pending", 32'(cfg_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
